conv_accumulator: RTL and testbench
===================================

Name: conv_accumulator

Overview:
- Stage directly downstream of the 3x3 convolution multiplier layer.
- Takes the nine signed 32-bit products of one window, adds them and a bias, then applies rounding, a fixed-point shift, optional ReLU and 16-bit saturation.
- Result is one output pixel.
- Three-stage pipeline with valid/ready flow control so the line-buffer/window front end can be stalled by the output writer.

Parameters:
- PROD_W, 32: width of each signed product input.
- OUT_W, 16: width of the signed saturated output pixel.
- FRAC_SHIFT, 8: arithmetic right shift applied to the sum; legal range 0..20.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  product set valid.
- in_ready  out  1  stage can accept a product set this cycle.
- in_last  in  1  marks last window of a frame; carried to out_last.
- p1..p9  in  PROD_W each  signed products, window order 1..9.
- bias  in  32  signed bias, same scale as products.
- relu_en  in  1  1 = clamp negative results to 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  OUT_W  signed result pixel.
- out_last  out  1  last flag aligned with out_data.
- busy  out  1  OR of all stage valid bits.

Behaviour:
- Reset (async assert, sync release):
  - v1, v2, v3 cleared.
  - out_data = 0, out_last = 0, out_valid = 0, busy = 0.
  - Partial-sum registers = 0.
  - Mid-operation reset discards all in-flight data, with no output pulse.
- Handshake:
  - Transfer on in_valid && in_ready, and on out_valid && out_ready.
  - out_valid = v3.
  - Stage k loads when (!v_k) or (stage k+1 loads, or out_ready for stage 3).
  - in_ready = stage-1 load condition, combinational from out_ready through v bits. This gives bubble collapsing.
  - No loss or duplication under any valid/ready pattern.
  - out_data and out_last are held stable while out_valid && !out_ready.
  - A stage whose predecessor is empty while it loads clears its valid bit.
- Stage 1:
  - s_a = p1+p2+p3, s_b = p4+p5+p6, s_c = p7+p8+p9, each PROD_W+2 bits, sign-extended.
  - bias and relu_en are registered alongside the data.
- Stage 2: sum = s_a+s_b+s_c+bias, PROD_W+4 bits signed, with no overflow possible.
- Stage 3:
  - If FRAC_SHIFT > 0, add 1<<(FRAC_SHIFT-1) (round half toward +inf), then arithmetic shift right by FRAC_SHIFT.
  - If relu_en and the result < 0, the result becomes 0.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Latency: 3 cycles from accepted input to out_valid with out_ready held high; throughput 1 result per cycle.
- Capacity: 3 entries. With out_ready low, exactly 3 sets are accepted, then in_ready = 0.
- in_last: travels with its data; out_last is valid only when out_valid.
- bias/relu_en: sampled per transfer, so changing them between windows is legal.

Decomposition:
- Shared package conv_pkg:
  - PROD_W, OUT_W, FRAC_SHIFT defaults.
  - Saturation bounds.
  - The rounding-constant function.
- Natural sub-module: conv_sat_round, combinational round/shift/ReLU/saturate used in stage 3. It is reusable by later pooling stages.

Test Plan:
- Rounding up: p1..p9 = 256, bias 0, FRAC_SHIFT 8, relu_en 0, out_ready 1 -> out_data = 9, 3 cycles after accept.
- Saturation: p1..p9 = 0x01000000 -> out_data = 32767. p1..p9 = 0xFF000000 -> out_data = -32768.
- ReLU: p1..p9 = -256 -> out_data 0xFFF7 (-9) with relu_en 0; out_data 0 with relu_en 1.
- Rounding and bias:
  - p1 = 384, others 0 -> 2.
  - p1 = -384 -> -1.
  - bias = 512, all p = 0 -> 2.
- Backpressure: stream 6 sets with values 1..6 (scaled by 256, in p1 only), out_ready low for 5 cycles.
  - Required: exactly 3 accepted, then in_ready = 0.
  - Outputs 1..6 in order with no gaps or repeats once out_ready rises.
  - out_data stable while stalled.
  - Each set's out_last matches its input.
- Reset: assert rst_n low while 2 sets are in flight -> out_valid and busy drop immediately and out_data = 0. After release, one new set produces exactly one output.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and helpers for the convolution accumulator and later
// pooling stages: default widths, saturation bounds and the rounding constant.
package conv_pkg;

  localparam int DEF_PROD_W     = 32;
  localparam int DEF_OUT_W      = 16;
  localparam int DEF_FRAC_SHIFT = 8;

  function automatic longint sat_hi(int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_lo(int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Half an output LSB, so the shift rounds half toward +inf
  function automatic longint round_const(int sh);
    return (sh > 0) ? (64'sd1 <<< (sh - 1)) : 64'sd0;
  endfunction

  localparam longint SAT_MAX = sat_hi(DEF_OUT_W);
  localparam longint SAT_MIN = sat_lo(DEF_OUT_W);

endpackage

// File: rtl/conv_sat_round.sv
// Combinational round, arithmetic shift, optional ReLU and signed saturation.
// One extra bit of headroom keeps the rounding add from overflowing.
module conv_sat_round
  import conv_pkg::*;
#(
  parameter int IN_W  = DEF_PROD_W + 4,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_FRAC_SHIFT
) (
  input  logic signed [IN_W-1:0]  d,
  input  logic                    relu_en,
  output logic signed [OUT_W-1:0] q
);

  localparam int EW = IN_W + 1;
  localparam logic signed [EW-1:0] RC = EW'(round_const(SHIFT));
  localparam logic signed [EW-1:0] HI = EW'(sat_hi(OUT_W));
  localparam logic signed [EW-1:0] LO = EW'(sat_lo(OUT_W));

  logic signed [EW-1:0] rnd;
  logic signed [EW-1:0] shf;

  always_comb begin
    rnd = EW'(d) + RC;
    shf = rnd >>> SHIFT;
    if (relu_en && shf[EW-1])
      q = '0;
    else if (shf > HI)
      q = HI[OUT_W-1:0];
    else if (shf < LO)
      q = LO[OUT_W-1:0];
    else
      q = shf[OUT_W-1:0];
  end

endmodule

// File: rtl/conv_accumulator.sv
// Three-stage accumulator behind the 3x3 multiplier layer: partial sums,
// bias add, then round/shift/ReLU/saturate, with collapsing valid/ready.
module conv_accumulator
  import conv_pkg::*;
#(
  parameter int PROD_W     = DEF_PROD_W,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int FRAC_SHIFT = DEF_FRAC_SHIFT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic signed [PROD_W-1:0] p1,
  input  logic signed [PROD_W-1:0] p2,
  input  logic signed [PROD_W-1:0] p3,
  input  logic signed [PROD_W-1:0] p4,
  input  logic signed [PROD_W-1:0] p5,
  input  logic signed [PROD_W-1:0] p6,
  input  logic signed [PROD_W-1:0] p7,
  input  logic signed [PROD_W-1:0] p8,
  input  logic signed [PROD_W-1:0] p9,
  input  logic signed [31:0]       bias,
  input  logic                     relu_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_last,
  output logic                     busy
);

  localparam int SW   = PROD_W + 2;
  localparam int SUMW = PROD_W + 4;

  logic                   v1, v2, v3;
  logic                   ld1, ld2, ld3;
  logic signed [SW-1:0]   s_a, s_b, s_c;
  logic signed [31:0]     bias1;
  logic                   relu1, last1;
  logic signed [SUMW-1:0] sum;
  logic                   relu2, last2;
  logic signed [OUT_W-1:0] sat_q;

  // Each stage can take new data if empty or if it drains this cycle
  assign ld3       = !v3 || out_ready;
  assign ld2       = !v2 || ld3;
  assign ld1       = !v1 || ld2;
  assign in_ready  = ld1;
  assign out_valid = v3;
  assign busy      = v1 || v2 || v3;

  conv_sat_round #(
    .IN_W  (SUMW),
    .OUT_W (OUT_W),
    .SHIFT (FRAC_SHIFT)
  ) u_sat (
    .d       (sum),
    .relu_en (relu2),
    .q       (sat_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      s_a      <= '0;
      s_b      <= '0;
      s_c      <= '0;
      bias1    <= '0;
      relu1    <= 1'b0;
      last1    <= 1'b0;
      sum      <= '0;
      relu2    <= 1'b0;
      last2    <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      if (ld1) begin
        v1 <= in_valid;
        if (in_valid) begin
          s_a   <= SW'(p1) + SW'(p2) + SW'(p3);
          s_b   <= SW'(p4) + SW'(p5) + SW'(p6);
          s_c   <= SW'(p7) + SW'(p8) + SW'(p9);
          bias1 <= bias;
          relu1 <= relu_en;
          last1 <= in_last;
        end
      end
      if (ld2) begin
        v2 <= v1;
        if (v1) begin
          sum   <= SUMW'(s_a) + SUMW'(s_b)
                 + SUMW'(s_c) + SUMW'(bias1);
          relu2 <= relu1;
          last2 <= last1;
        end
      end
      if (ld3) begin
        v3 <= v2;
        if (v2) begin
          out_data <= sat_q;
          out_last <= last2;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_accumulator.sv
// Directed bench for conv_accumulator: table of single windows, then
// backpressure streaming and mid-flight reset sequences.
module tb_conv_accumulator;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic               in_last;
  logic signed [31:0] p [1:9];
  logic signed [31:0] bias;
  logic               relu_en;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               out_last;
  logic               busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int pall;
    int p1x;
    int bias;
    bit relu;
    bit last;
    int exp;
  } vec_t;

  vec_t vecs [16];

  always #5 clk = ~clk;

  conv_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .p1        (p[1]),
    .p2        (p[2]),
    .p3        (p[3]),
    .p4        (p[4]),
    .p5        (p[5]),
    .p6        (p[6]),
    .p7        (p[7]),
    .p8        (p[8]),
    .p9        (p[9]),
    .bias      (bias),
    .relu_en   (relu_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic check(input string name, input longint act,
                       input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int pall, input int p1x, input int b,
                       input bit relu, input bit last);
    for (int k = 1; k <= 9; k++) p[k] = pall;
    p[1]    = pall + p1x;
    bias    = b;
    relu_en = relu;
    in_last = last;
  endtask

  initial begin
    int cnt;
    int sent;
    int recv;
    int nout;
    int got;
    bit stall_prev;
    int hold_data;
    bit hold_last;

    vecs[0]  = '{pall: 256,       p1x: 0,        bias: 0,     relu: 0, last: 0, exp: 9};
    vecs[1]  = '{pall: 16777216,  p1x: 0,        bias: 0,     relu: 0, last: 1, exp: 32767};
    vecs[2]  = '{pall: -16777216, p1x: 0,        bias: 0,     relu: 0, last: 0, exp: -32768};
    vecs[3]  = '{pall: -256,      p1x: 0,        bias: 0,     relu: 0, last: 0, exp: -9};
    vecs[4]  = '{pall: -256,      p1x: 0,        bias: 0,     relu: 1, last: 1, exp: 0};
    vecs[5]  = '{pall: 0,         p1x: 384,      bias: 0,     relu: 0, last: 0, exp: 2};
    vecs[6]  = '{pall: 0,         p1x: -384,     bias: 0,     relu: 0, last: 1, exp: -1};
    vecs[7]  = '{pall: 0,         p1x: 0,        bias: 512,   relu: 0, last: 0, exp: 2};
    vecs[8]  = '{pall: 0,         p1x: 1000,     bias: 0,     relu: 1, last: 0, exp: 4};
    vecs[9]  = '{pall: 0,         p1x: 127,      bias: 0,     relu: 0, last: 0, exp: 0};
    vecs[10] = '{pall: 0,         p1x: 128,      bias: 0,     relu: 0, last: 1, exp: 1};
    vecs[11] = '{pall: 0,         p1x: 8388224,  bias: 0,     relu: 0, last: 0, exp: 32767};
    vecs[12] = '{pall: 0,         p1x: 8388480,  bias: 0,     relu: 0, last: 0, exp: 32767};
    vecs[13] = '{pall: 0,         p1x: -8388736, bias: 0,     relu: 0, last: 0, exp: -32768};
    vecs[14] = '{pall: 0,         p1x: -8388737, bias: 0,     relu: 0, last: 1, exp: -32768};
    vecs[15] = '{pall: 100,       p1x: 0,        bias: -1000, relu: 0, last: 0, exp: 0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(0, 0, 0, 1'b0, 1'b0);
    #22;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_in_ready", in_ready, 1);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].pall, vecs[i].p1x, vecs[i].bias,
            vecs[i].relu, vecs[i].last);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cnt = 1;
      while (!out_valid && cnt < 10) begin
        @(posedge clk);
        #1;
        cnt++;
      end
      check($sformatf("vec%0d_latency", i), cnt, 3);
      got = out_data;
      check($sformatf("vec%0d_data", i), got, vecs[i].exp);
      check($sformatf("vec%0d_last", i), out_last, vecs[i].last);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_drained", i), out_valid, 0);
    end

    sent = 0;
    recv = 0;
    stall_prev = 1'b0;
    hold_data = 0;
    hold_last = 1'b0;
    for (int c = 0; c < 40 && recv < 6; c++) begin
      in_valid  = (sent < 6);
      drive(0, (sent + 1) * 256, 0, 1'b0, ((sent + 1) % 3) == 0);
      out_ready = (c >= 5);
      #1;
      if (c == 4) begin
        check("bp_accepted", sent, 3);
        check("bp_in_ready", in_ready, 0);
      end
      if (stall_prev) begin
        got = out_data;
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_data", got, hold_data);
        check("bp_hold_last", out_last, hold_last);
      end
      if (c >= 5) check("bp_no_gap", out_valid, 1);
      if (out_valid && out_ready) begin
        got = out_data;
        check("bp_data", got, recv + 1);
        check("bp_last", out_last, ((recv + 1) % 3) == 0);
        recv++;
      end
      stall_prev = out_valid && !out_ready;
      hold_data  = out_data;
      hold_last  = out_last;
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("bp_recv_count", recv, 6);
    @(posedge clk);
    #1;
    check("bp_empty_valid", out_valid, 0);
    check("bp_empty_busy", busy, 0);

    out_ready = 1'b0;
    drive(0, 7 * 256, 0, 1'b0, 1'b1);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    drive(0, 8 * 256, 0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rs_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rs_valid", out_valid, 0);
    check("rs_busy", busy, 0);
    check("rs_data", out_data, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    drive(0, 5 * 256, 0, 1'b0, 1'b1);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    nout = 0;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) begin
        nout++;
        got = out_data;
      end
      @(posedge clk);
      #1;
    end
    check("rs_out_count", nout, 1);
    check("rs_out_data", got, 5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
